// File: rtl/snn_pkg.sv
// Shared SNN definitions: sequencer state encoding and the potential and index
// width helpers. The neuron datapath uses the same u_w() so that both sides
// agree on the potential width.
package snn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // Membrane potential width for a given adder-tree depth.
    function automatic int u_w(input int n_stage);
        return n_stage + 2;
    endfunction

    // Neuron index width. It is never narrower than one bit.
    function automatic int idx_w(input int n_neurons);
        return (n_neurons < 2) ? 1 : $clog2(n_neurons);
    endfunction

endpackage

// File: rtl/neuron_state_regfile.sv
// Per-neuron storage: the membrane potential and the last spike flag.
// Reads are combinational at idx. There is one write port with an enable and
// a synchronous clear. An asynchronous reset zeroes every entry.
// The whole spike column is also exported so that the controller can take a
// snapshot of it.
module neuron_state_regfile
    import snn_pkg::*;
#(
    parameter int N_NEURONS = 4,
    parameter int U_W       = 4,
    parameter int IDX_W     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 we,
    input  logic [IDX_W-1:0]     idx,
    input  logic [U_W-1:0]       wr_u,
    input  logic                 wr_spk,
    output logic [U_W-1:0]       rd_u,
    output logic                 rd_spk,
    output logic [N_NEURONS-1:0] spk_all
);

    // Each entry is {spike, potential}.
    logic [U_W:0] entry [N_NEURONS];

    for (genvar gi = 0; gi < N_NEURONS; gi++) begin : g_entry
        logic [U_W:0] entry_reg;

        // Entry update: the clear takes priority over a write to this index.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                entry_reg <= '0;
            end else if (clr) begin
                entry_reg <= '0;
            end else if (we && (idx == IDX_W'(gi))) begin
                entry_reg <= {wr_spk, wr_u};
            end
        end

        assign entry[gi]   = entry_reg;
        assign spk_all[gi] = entry_reg[U_W];
    end

    assign rd_u   = entry[idx][U_W-1:0];
    assign rd_spk = entry[idx][U_W];

endmodule

// File: rtl/neuron_state_sequencer.sv
// Shares one neuron datapath across N_NEURONS logical neurons. Each start
// pulse runs one timestep, handling one neuron per cycle. The stored state of
// neuron_idx goes out to the datapath, and the datapath result is written back.
// Optional feature: define SPIKE_COUNT_EN to add the spike_count output.
module neuron_state_sequencer
    import snn_pkg::*;
#(
    parameter  int N_STAGE   = 2,
    parameter  int N_NEURONS = 4,
    localparam int U_W       = u_w(N_STAGE),
    localparam int IDX_W     = idx_w(N_NEURONS)
`ifdef SPIKE_COUNT_EN
    ,
    localparam int CNT_W     = $clog2(N_NEURONS + 1)
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 clear_state,
    input  logic [U_W-1:0]       u_in,
    input  logic                 spike_in,
    output logic [IDX_W-1:0]     neuron_idx,
    output logic [U_W-1:0]       prev_u,
    output logic                 was_spike,
    output logic                 busy,
    output logic                 done,
`ifdef SPIKE_COUNT_EN
    output logic [CNT_W-1:0]     spike_count,
`endif
    output logic [N_NEURONS-1:0] spike_vec
);

    seq_state_t           state_reg, state_next;
    logic [IDX_W-1:0]     idx_reg, idx_next;
    logic [N_NEURONS-1:0] spike_vec_reg;
    logic [N_NEURONS-1:0] spk_all;
    logic                 mem_we;
    logic                 mem_clr;

    neuron_state_regfile #(
        .N_NEURONS (N_NEURONS),
        .U_W       (U_W),
        .IDX_W     (IDX_W)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .clr     (mem_clr),
        .we      (mem_we),
        .idx     (idx_reg),
        .wr_u    (u_in),
        .wr_spk  (spike_in),
        .rd_u    (prev_u),
        .rd_spk  (was_spike),
        .spk_all (spk_all)
    );

    // Next-state, index stepping and memory control.
    // A start pulse outranks clear_state in IDLE. Both inputs are ignored
    // while busy.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        mem_we     = 1'b0;
        mem_clr    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    idx_next   = '0;
                end else if (clear_state) begin
                    mem_clr = 1'b1;
                end
            end
            RUN: begin
                busy   = 1'b1;
                mem_we = 1'b1;
                if (idx_reg == IDX_W'(N_NEURONS - 1)) begin
                    state_next = DONE;
                    idx_next   = '0;
                end else begin
                    idx_next = IDX_W'(idx_reg + 1'b1);
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

    // State and index registers. The spike snapshot updates only in DONE, so
    // a partially written timestep is never visible on spike_vec.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            spike_vec_reg <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            if (state_reg == DONE) begin
                spike_vec_reg <= spk_all;
            end
        end
    end

`ifdef SPIKE_COUNT_EN
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] spike_count_reg;

    // Count the spikes written during this run, and publish the total in DONE
    // together with spike_vec.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg         <= '0;
            spike_count_reg <= '0;
        end else begin
            if (state_reg == IDLE && start) begin
                cnt_reg <= '0;
            end else if (state_reg == RUN && spike_in) begin
                cnt_reg <= CNT_W'(cnt_reg + 1'b1);
            end
            if (state_reg == DONE) begin
                spike_count_reg <= cnt_reg;
            end
        end
    end

    assign spike_count = spike_count_reg;
`endif

    assign neuron_idx = idx_reg;
    assign spike_vec  = spike_vec_reg;

endmodule

// File: tb/tb_neuron_state_sequencer.sv
// Directed, table-driven bench for neuron_state_sequencer with N_STAGE=2 and N_NEURONS=4.
// Define SPIKE_COUNT_EN to also check spike_count.
module tb_neuron_state_sequencer;
    import snn_pkg::*;

    localparam int N   = 4;
    localparam int U_W = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         clear_state = 1'b0;
    logic [U_W-1:0] u_in = '0;
    logic         spike_in = 1'b0;
    logic [1:0]   neuron_idx;
    logic [U_W-1:0] prev_u;
    logic         was_spike;
    logic         busy;
    logic         done;
    logic [N-1:0] spike_vec;
`ifdef SPIKE_COUNT_EN
    logic [2:0]   spike_count;
`endif

    neuron_state_sequencer #(.N_STAGE(2), .N_NEURONS(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .clear_state (clear_state),
        .u_in        (u_in),
        .spike_in    (spike_in),
        .neuron_idx  (neuron_idx),
        .prev_u      (prev_u),
        .was_spike   (was_spike),
        .busy        (busy),
        .done        (done),
`ifdef SPIKE_COUNT_EN
        .spike_count (spike_count),
`endif
        .spike_vec   (spike_vec)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [U_W-1:0] u;     // u_in driven in this RUN cycle
        logic           spk;   // spike_in driven in this RUN cycle
        logic           clr;   // clear_state asserted during RUN
        logic           stt;   // start re-pulsed during RUN
        int             idx;   // expected neuron_idx
        logic [U_W-1:0] pu;    // expected prev_u
        logic           ws;    // expected was_spike
    } vec_t;

    vec_t tv [24];
    logic [N-1:0] exp_vec [6];
    int           exp_cnt [6];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_run(input int r,
                           input logic [U_W-1:0] u0, u1, u2, u3,
                           input logic [3:0] spk,
                           input logic [3:0] clr,
                           input logic [3:0] stt,
                           input logic [U_W-1:0] p0, p1, p2, p3,
                           input logic [3:0] ws,
                           input logic [N-1:0] vec,
                           input int cnt);
        logic [U_W-1:0] uu [4];
        logic [U_W-1:0] pp [4];
        uu[0] = u0; uu[1] = u1; uu[2] = u2; uu[3] = u3;
        pp[0] = p0; pp[1] = p1; pp[2] = p2; pp[3] = p3;
        for (int k = 0; k < 4; k++) begin
            tv[r*4+k] = '{uu[k], spk[k], clr[k], stt[k], k, pp[k], ws[k]};
        end
        exp_vec[r] = vec;
        exp_cnt[r] = cnt;
    endtask

    // Run one timestep from table run r. With abort set, reset is asserted
    // asynchronously partway through the RUN cycle at idx 2.
    task automatic do_run(input int r, input bit abort);
        @(negedge clk);
        start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            u_in        = tv[r*4+k].u;
            spike_in    = tv[r*4+k].spk;
            clear_state = tv[r*4+k].clr;
            start       = tv[r*4+k].stt;
            check($sformatf("r%0d idx", r), neuron_idx, tv[r*4+k].idx);
            check($sformatf("r%0d k%0d prev_u", r, k), prev_u, tv[r*4+k].pu);
            check($sformatf("r%0d k%0d was_spike", r, k), was_spike, tv[r*4+k].ws);
            check($sformatf("r%0d k%0d busy", r, k), busy, 1);
            check($sformatf("r%0d k%0d done", r, k), done, 0);
            if (abort && k == 2) begin
                #1 reset = 1'b1;
                #1;
                check("async rst busy", busy, 0);
                check("async rst idx", neuron_idx, 0);
                check("async rst done", done, 0);
                check("async rst spike_vec", spike_vec, 0);
                check("async rst prev_u", prev_u, 0);
                start = 1'b0; clear_state = 1'b0; spike_in = 1'b0; u_in = '0;
                @(negedge clk);
                reset = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    check("post-rst done", done, 0);
                    check("post-rst busy", busy, 0);
                end
                $display("run %0d aborted by reset at idx 2", r);
                return;
            end
        end
        @(negedge clk);
        start = 1'b0; clear_state = 1'b0; spike_in = 1'b0; u_in = '0;
        check($sformatf("r%0d done pulse", r), done, 1);
        check($sformatf("r%0d done busy", r), busy, 1);
        check($sformatf("r%0d done idx", r), neuron_idx, 0);
        @(negedge clk);
        check($sformatf("r%0d done low", r), done, 0);
        check($sformatf("r%0d idle busy", r), busy, 0);
        check($sformatf("r%0d spike_vec", r), spike_vec, exp_vec[r]);
`ifdef SPIKE_COUNT_EN
        check($sformatf("r%0d spike_count", r), spike_count, exp_cnt[r]);
`endif
        @(negedge clk);
        check($sformatf("r%0d no requeue busy", r), busy, 0);
        check($sformatf("r%0d no second done", r), done, 0);
        $display("run %0d complete: spike_vec=%b", r, spike_vec);
    endtask

    initial begin
        //      r  u0 u1 u2 u3  spk      clr      stt      p0 p1 p2 p3  ws       vec      cnt
        set_run(0, 3, 5, 1, 7, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 0);
        set_run(1, 2, 4, 6, 0, 4'b1010, 4'b0000, 4'b0000, 3, 5, 1, 7, 4'b0000, 4'b1010, 2);
        set_run(2, 1, 1, 1, 1, 4'b0001, 4'b0110, 4'b0100, 2, 4, 6, 0, 4'b1010, 4'b0001, 1);
        set_run(3, 5, 5, 5, 5, 4'b0110, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0110, 2);
        set_run(4, 9, 9, 9, 9, 4'b1111, 4'b0000, 4'b0000, 5, 5, 5, 5, 4'b0110, 4'b0000, 0);
        set_run(5, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 0);

        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset spike_vec", spike_vec, 0);
        check("reset prev_u", prev_u, 0);
        check("reset idx", neuron_idx, 0);
        check("reset was_spike", was_spike, 0);
        $display("reset state checked");

        do_run(0, 1'b0);
        do_run(1, 1'b0);
        do_run(2, 1'b0);

        // Clear in IDLE wipes the stored state but not the spike snapshot.
        @(negedge clk);
        clear_state = 1'b1;
        @(negedge clk);
        clear_state = 1'b0;
        check("clear busy", busy, 0);
        check("clear prev_u idx0", prev_u, 0);
        check("clear spike_vec kept", spike_vec, 4'b0001);
        $display("clear_state applied in IDLE");

        do_run(3, 1'b0);
        do_run(4, 1'b1);
        do_run(5, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time limit, so that the run always ends.
    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/neuron_state_sequencer.md
Name: neuron_state_sequencer

Overview:
- Time-multiplexes one combinational neuron datapath across N_NEURONS logical neurons.
- Holds each neuron's membrane potential and last-spike flag in registers.
- Per neuron, presents previus_u and was_spike to the neuron datapath, then writes back the returned u_out and is_spike.
- Sits directly upstream and downstream of the neuron datapath; is driven by the layer/timestep controller.

Parameters:
- N_STAGE, 2, neuron adder-tree depth; potential width U_W = N_STAGE+2.
- N_NEURONS, 4, logical neurons sequenced per timestep (>=2).
- IDX_W, $clog2(N_NEURONS), neuron index width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse: run one timestep over all neurons.
- clear_state  in  1  zero all stored potentials and spike flags (IDLE only).
- u_in  in  U_W  u_out from neuron datapath for current index.
- spike_in  in  1  is_spike from neuron datapath for current index.
- neuron_idx  out  IDX_W  current neuron index; selects w/x externally.
- prev_u  out  U_W  to neuron previus_u: stored potential of neuron_idx.
- was_spike  out  1  to neuron was_spike: stored spike flag of neuron_idx.
- busy  out  1  high while sequencing.
- done  out  1  one-cycle pulse when the timestep completes.
- spike_vec  out  N_NEURONS  spike flags of the last completed timestep; bit i = neuron i.

Behaviour:
- Reset (async, any state): FSM=IDLE; idx=0; all u_mem, spk_mem and spike_vec =0; busy=0; done=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 -> RUN, idx=0. clear_state=1 (and start=0) -> all u_mem, spk_mem =0 next edge. Both high: start wins; clear ignored.
  - RUN: one neuron per cycle. prev_u = u_mem[idx] and was_spike = spk_mem[idx], combinational from registers. At each edge, u_mem[idx]<=u_in and spk_mem[idx]<=spike_in. idx==N_NEURONS-1 -> DONE and idx<=0; otherwise idx<=idx+1.
  - DONE: done=1 for exactly one cycle; spike_vec<=spk_mem (including final write); -> IDLE.
- busy=1 in RUN and DONE, else 0.
- start while busy: ignored, not queued. clear_state while busy: ignored.
- Latency: start sampled at edge 0; RUN cycles are edges 1..N_NEURONS; done high in cycle N_NEURONS+1; next start accepted the following cycle.
- neuron_idx=0 and prev_u/was_spike reflect neuron 0 while IDLE. The datapath output is don't-care and is not written.
- No arithmetic here. u_in is stored verbatim, with no saturation or wrap; the neuron datapath owns reset-by-subtraction.
- spike_vec stays stable between DONE pulses; partial results are never visible.
- Reset mid-RUN: all state is lost, no done pulse, memories zeroed.

Optional Feature:
- Macro SPIKE_COUNT_EN.
- Defined: extra output spike_count (width $clog2(N_NEURONS+1)).
  - Counts spike_in=1 writes during the current RUN; cleared at the RUN entry edge.
  - Registered to the output at DONE, alongside spike_vec.
  - Reset value 0.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package snn_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - localparam functions for U_W=N_STAGE+2 and IDX_W.
  The neuron datapath reuses the same U_W definition.
- One natural sub-module: neuron_state_regfile. It holds the N_NEURONS x (U_W+1) storage, with one combinational read port at idx, one write port with enable, and a synchronous clear. The FSM, index counter and spike_vec stay in the top.

Test Plan:
- Reset then idle 5 cycles -> busy=0, done=0, spike_vec=0, prev_u=0, neuron_idx=0.
- Writeback: start with N=4, u_in driven 3,5,1,7 on successive RUN cycles, spike_in=0 -> done at cycle 5. Second start -> prev_u reads 3,5,1,7 at idx 0..3.
- Spike capture: spike_in=1 only at idx 1 and 3 -> spike_vec=4'b1010 after done. Next run shows was_spike 0,1,0,1. With SPIKE_COUNT_EN, spike_count=2.
- start pulsed again at RUN cycle 2 -> ignored; exactly one done pulse; idx runs 0..3 once.
- clear_state in IDLE after a run with nonzero state -> all prev_u=0 and was_spike=0 on next run. clear_state asserted mid-RUN -> no effect.
- Reset asserted asynchronously at RUN idx 2 -> immediately busy=0 and idx=0; no done; all stored potentials read 0 afterwards.
